// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants and types for the UART command sequencer.
//   - ASCII codes for the command, digit and terminator characters
//   - FSM state encoding (3 bits)
//   - Range limits for hour and minute/second fields
package uart_cmd_pkg;

  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  localparam logic [6:0] MAX_HOUR   = 7'd23;
  localparam logic [6:0] MAX_MINSEC = 7'd59;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIGITS  = 3'd1,
    WAIT_CR = 3'd2,
    CHECK   = 3'd3,
    ISSUE   = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/uart_cmd_bcd2bin.sv
// uart_cmd_bcd2bin: combinational two-digit decimal to binary converter
// with an upper-bound check.
// Ports:
//   d_hi     in  4  tens digit (0-9)
//   d_lo     in  4  units digit (0-9)
//   limit    in  7  largest accepted value
//   value    out 7  d_hi*10 + d_lo
//   in_range out 1  value <= limit
module uart_cmd_bcd2bin (
  input  logic [3:0] d_hi,
  input  logic [3:0] d_lo,
  input  logic [6:0] limit,
  output logic [6:0] value,
  output logic       in_range
);

  // x*10 = x*8 + x*2; the largest result (99) fits in 7 bits
  assign value    = {d_hi, 3'b000} + {2'b00, d_hi, 1'b0} + {3'b000, d_lo};
  assign in_range = (value <= limit);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles "T"/"A" + HHMMSS + CR frames from the UART
// receive stream, validates them and issues a one-cycle set-time or
// set-alarm strobe with the binary H/M/S. Malformed frames give a
// one-cycle o_err pulse and the block waits for the next command char.
//
// Optional feature (macro CMD_TIMEOUT_EN): an inter-byte timeout that
// aborts a partial frame with o_err after TIMEOUT_CLKS idle cycles.
//
// Ports:
//   i_clk        in   1  system clock
//   i_rst_n      in   1  asynchronous active-low reset
//   i_rx_valid   in   1  received-byte strobe
//   i_rx_byte    in   8  received byte
//   o_set_time   out  1  load H/M/S into the time counter (1 cycle)
//   o_set_alarm  out  1  load H/M/S into the alarm register (1 cycle)
//   o_hour       out  5  committed hour
//   o_min        out  6  committed minute
//   o_sec        out  6  committed second
//   o_err        out  1  frame rejected (1 cycle)
//   o_busy       out  1  a frame is in progress
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 5000000,
  parameter int TO_W         = 23
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_set_time,
  output logic       o_set_alarm,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic       o_err,
  output logic       o_busy
);

  state_t          state, state_nxt;
  logic [2:0]      idx;
  logic [5:0][3:0] dig;
  logic            cmd_alarm;

  logic rx_cmd, rx_dig, rx_cr;
  logic to_hit;
  logic err_nxt, st_nxt, al_nxt;

  logic [6:0] hr_val, mn_val, sc_val;
  logic       hr_ok, mn_ok, sc_ok, all_ok;

  assign rx_cmd = (i_rx_byte == CH_T) || (i_rx_byte == CH_A);
  assign rx_dig = is_digit(i_rx_byte);
  assign rx_cr  = (i_rx_byte == CH_CR);

  // ---------------------------------------------------------------
  // BCD pairs to binary; the buffer is stable through CHECK and ISSUE
  // ---------------------------------------------------------------
  uart_cmd_bcd2bin u_hour (
    .d_hi(dig[0]), .d_lo(dig[1]), .limit(MAX_HOUR),
    .value(hr_val), .in_range(hr_ok)
  );
  uart_cmd_bcd2bin u_min (
    .d_hi(dig[2]), .d_lo(dig[3]), .limit(MAX_MINSEC),
    .value(mn_val), .in_range(mn_ok)
  );
  uart_cmd_bcd2bin u_sec (
    .d_hi(dig[4]), .d_lo(dig[5]), .limit(MAX_MINSEC),
    .value(sc_val), .in_range(sc_ok)
  );

  assign all_ok = hr_ok && mn_ok && sc_ok;

  // range check guarantees the dropped upper bits are zero when committed
  logic unused_hi;
  assign unused_hi = ^{hr_val[6:5], mn_val[6], sc_val[6]};

  // ---------------------------------------------------------------
  // Inter-byte timeout
  // ---------------------------------------------------------------
`ifdef CMD_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            in_frame;

  assign in_frame = (state == DIGITS) || (state == WAIT_CR);
  // a byte on the expiry cycle takes priority over the timeout
  assign to_hit   = in_frame && !i_rx_valid &&
                    (to_cnt == TO_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      to_cnt <= '0;
    else if (i_rx_valid || (state == IDLE) || to_hit)
      to_cnt <= '0;
    else if (in_frame)
      to_cnt <= to_cnt + TO_W'(1);
  end
`else
  assign to_hit = 1'b0;

  logic unused_to_cfg;
  assign unused_to_cfg = ^{TIMEOUT_CLKS[0], TO_W[0]};
`endif

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_rx_valid && rx_cmd) state_nxt = DIGITS;
      end
      DIGITS: begin
        if (i_rx_valid) begin
          if (!rx_dig)          state_nxt = IDLE;
          else if (idx == 3'd5) state_nxt = WAIT_CR;
        end else if (to_hit) begin
          state_nxt = IDLE;
        end
      end
      WAIT_CR: begin
        if (i_rx_valid)  state_nxt = rx_cr ? CHECK : IDLE;
        else if (to_hit) state_nxt = IDLE;
      end
      CHECK:   state_nxt = all_ok ? ISSUE : IDLE;
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs (next values of the registered pulses)
  // ---------------------------------------------------------------
  always_comb begin
    err_nxt = 1'b0;
    st_nxt  = 1'b0;
    al_nxt  = 1'b0;
    unique case (state)
      DIGITS:  err_nxt = (i_rx_valid && !rx_dig) || to_hit;
      WAIT_CR: err_nxt = (i_rx_valid && !rx_cr) || to_hit;
      CHECK:   err_nxt = !all_ok;
      ISSUE: begin
        st_nxt = !cmd_alarm;
        al_nxt = cmd_alarm;
      end
      default: ;
    endcase
  end

  assign o_busy = (state != IDLE);

  // ---------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_set_time  <= 1'b0;
      o_set_alarm <= 1'b0;
      o_err       <= 1'b0;
      o_hour      <= '0;
      o_min       <= '0;
      o_sec       <= '0;
      idx         <= '0;
      dig         <= '0;
      cmd_alarm   <= 1'b0;
    end else begin
      o_set_time  <= st_nxt;
      o_set_alarm <= al_nxt;
      o_err       <= err_nxt;

      // committed values move only together with a strobe
      if (state == ISSUE) begin
        o_hour <= hr_val[4:0];
        o_min  <= mn_val[5:0];
        o_sec  <= sc_val[5:0];
      end

      if ((state == IDLE) && i_rx_valid && rx_cmd) begin
        cmd_alarm <= (i_rx_byte == CH_A);
        idx       <= '0;
      end else if ((state == DIGITS) && i_rx_valid && rx_dig) begin
        dig[idx] <= i_rx_byte[3:0];
        idx      <= idx + 3'd1;
      end
    end
  end

endmodule
